// File: rtl/ball_collision_engine_if.sv
// ball_collision_engine_if: request/result bundle between the frame-tick
// scheduler (master) and the ball collision engine (slave).
//   start                 : begin one ball update
//   ball_x/ball_y         : current ball position, unsigned
//   ball_dir_x/ball_dir_y : current velocity, signed two's complement
//   player_x/player_y     : packed player positions, player i at [i*COORD_W +: COORD_W]
//   busy/done             : update in flight / one-cycle completion pulse
//   new_ball_*            : next position and velocity
//   hit_mask              : bit i set when player i overlapped the ball
interface ball_collision_engine_if #(
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned NUM_PLAYERS = 2
);
    logic                           start;
    logic [COORD_W-1:0]             ball_x;
    logic [COORD_W-1:0]             ball_y;
    logic [COORD_W-1:0]             ball_dir_x;
    logic [COORD_W-1:0]             ball_dir_y;
    logic [NUM_PLAYERS*COORD_W-1:0] player_x;
    logic [NUM_PLAYERS*COORD_W-1:0] player_y;
    logic                           busy;
    logic                           done;
    logic [COORD_W-1:0]             new_ball_x;
    logic [COORD_W-1:0]             new_ball_y;
    logic [COORD_W-1:0]             new_ball_dir_x;
    logic [COORD_W-1:0]             new_ball_dir_y;
    logic [NUM_PLAYERS-1:0]         hit_mask;

    modport master (
        output start, ball_x, ball_y, ball_dir_x, ball_dir_y, player_x, player_y,
        input  busy, done, new_ball_x, new_ball_y, new_ball_dir_x, new_ball_dir_y, hit_mask
    );

    modport slave (
        input  start, ball_x, ball_y, ball_dir_x, ball_dir_y, player_x, player_y,
        output busy, done, new_ball_x, new_ball_y, new_ball_dir_x, new_ball_dir_y, hit_mask
    );
endinterface

// File: rtl/ball_collision_engine.sv
// ball_collision_engine: sequential ball update. On start it latches the ball
// and all player positions, scans players one per cycle reflecting off the
// first overlapping one, reflects off the field walls, clamps the moved ball
// into the field and reports the result with a one-cycle done pulse.
// Ports: clk, rst (synchronous, active high), bus (ball_collision_engine_if.slave).
// Optional feature: define BALL_SPEEDUP_EN to grow a player-reflected velocity
// component by 1 (saturating at MAX_SPEED).
module ball_collision_engine #(
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned RADIUS      = 16,
    parameter int unsigned FIELD_W     = 640,
    parameter int unsigned FIELD_H     = 480,
    parameter int unsigned MAX_SPEED   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    ball_collision_engine_if.slave bus
);
    localparam int unsigned EW    = COORD_W + 2;
    localparam int unsigned IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic signed [EW-1:0]  LO   = EW'(RADIUS);
    localparam logic signed [EW-1:0]  HI_X = EW'(FIELD_W - 1 - RADIUS);
    localparam logic signed [EW-1:0]  HI_Y = EW'(FIELD_H - 1 - RADIUS);
    localparam logic [IDX_W-1:0]      LAST = IDX_W'(NUM_PLAYERS - 1);
`ifdef BALL_SPEEDUP_EN
    localparam logic signed [COORD_W-1:0] SPEED_CAP = COORD_W'(MAX_SPEED);
`endif

    // Elaboration-time sanity check of the configuration
    if (NUM_PLAYERS < 1 || MAX_SPEED >= (1 << (COORD_W - 1))) begin : g_bad_cfg
        $error("ball_collision_engine: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, SCAN, WALL, MOVE, DONE} state_t;

    state_t                     state, state_n;
    logic [IDX_W-1:0]           idx, idx_n;
    logic                       hit, hit_n;
    logic [NUM_PLAYERS-1:0]     mask, mask_n;
    logic [COORD_W-1:0]         bx, bx_n, by, by_n;
    logic signed [COORD_W-1:0]  dx, dx_n, dy, dy_n;
    logic [COORD_W-1:0]         px_q [NUM_PLAYERS];
    logic [COORD_W-1:0]         py_q [NUM_PLAYERS];
    logic                       busy, busy_n, done, done_n;
    logic [COORD_W-1:0]         res_x, res_x_n, res_y, res_y_n;
    logic [COORD_W-1:0]         res_dx, res_dx_n, res_dy, res_dy_n;
    logic [NUM_PLAYERS-1:0]     res_mask, res_mask_n;

    logic [COORD_W-1:0]         cur_px, cur_py;
    logic signed [EW-1:0]       diff_x, diff_y, ax, ay, sum_x, sum_y;
    logic                       overlap;

    function automatic logic signed [COORD_W-1:0] mag_of(input logic signed [COORD_W-1:0] v);
        return v[COORD_W-1] ? -v : v;
    endfunction

    // Magnitude given to a component after a player reflection
    function automatic logic signed [COORD_W-1:0] hit_mag(input logic signed [COORD_W-1:0] v);
`ifdef BALL_SPEEDUP_EN
        logic signed [COORD_W-1:0] m;
        m = mag_of(v);
        return (m >= SPEED_CAP) ? SPEED_CAP : m + COORD_W'(1);
`else
        return mag_of(v);
`endif
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input logic signed [EW-1:0] s,
                                                input logic signed [EW-1:0] hi);
        if (s < LO) return COORD_W'(LO);
        if (s > hi) return COORD_W'(hi);
        return COORD_W'(s);
    endfunction

    // Distances to the scanned player and moved position, all at EW bits signed
    assign cur_px  = px_q[idx];
    assign cur_py  = py_q[idx];
    assign diff_x  = $signed({2'b00, bx}) - $signed({2'b00, cur_px});
    assign diff_y  = $signed({2'b00, by}) - $signed({2'b00, cur_py});
    assign ax      = diff_x[EW-1] ? -diff_x : diff_x;
    assign ay      = diff_y[EW-1] ? -diff_y : diff_y;
    assign overlap = (ax < LO) && (ay < LO);
    assign sum_x   = $signed({2'b00, bx}) + EW'(dx);
    assign sum_y   = $signed({2'b00, by}) + EW'(dy);

    // Next-state and next-register logic
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        hit_n      = hit;
        mask_n     = mask;
        bx_n       = bx;
        by_n       = by;
        dx_n       = dx;
        dy_n       = dy;
        busy_n     = 1'b1;
        done_n     = 1'b0;
        res_x_n    = res_x;
        res_y_n    = res_y;
        res_dx_n   = res_dx;
        res_dy_n   = res_dy;
        res_mask_n = res_mask;
        case (state)
            IDLE: begin
                busy_n = bus.start;
                if (bus.start) begin
                    state_n = SCAN;
                    idx_n   = '0;
                    hit_n   = 1'b0;
                    mask_n  = '0;
                    bx_n    = bus.ball_x;
                    by_n    = bus.ball_y;
                    dx_n    = bus.ball_dir_x;
                    dy_n    = bus.ball_dir_y;
                end
            end
            SCAN: begin
                if (overlap) begin
                    mask_n[idx] = 1'b1;
                    // Only the first overlapping player steers the ball
                    if (!hit) begin
                        hit_n = 1'b1;
                        if (ax >= ay) dx_n = (bx >= cur_px) ? hit_mag(dx) : -hit_mag(dx);
                        else          dy_n = (by >= cur_py) ? hit_mag(dy) : -hit_mag(dy);
                    end
                end
                if (idx == LAST) state_n = WALL;
                else             idx_n   = idx + IDX_W'(1);
            end
            WALL: begin
                if (sum_x < LO)        dx_n = mag_of(dx);
                else if (sum_x > HI_X) dx_n = -mag_of(dx);
                if (sum_y < LO)        dy_n = mag_of(dy);
                else if (sum_y > HI_Y) dy_n = -mag_of(dy);
                state_n = MOVE;
            end
            MOVE: begin
                bx_n    = clamp(sum_x, HI_X);
                by_n    = clamp(sum_y, HI_Y);
                state_n = DONE;
            end
            DONE: begin
                res_x_n    = bx;
                res_y_n    = by;
                res_dx_n   = dx;
                res_dy_n   = dy;
                res_mask_n = mask;
                done_n     = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            hit      <= 1'b0;
            mask     <= '0;
            bx       <= '0;
            by       <= '0;
            dx       <= '0;
            dy       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_x    <= '0;
            res_y    <= '0;
            res_dx   <= '0;
            res_dy   <= '0;
            res_mask <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            hit      <= hit_n;
            mask     <= mask_n;
            bx       <= bx_n;
            by       <= by_n;
            dx       <= dx_n;
            dy       <= dy_n;
            busy     <= busy_n;
            done     <= done_n;
            res_x    <= res_x_n;
            res_y    <= res_y_n;
            res_dx   <= res_dx_n;
            res_dy   <= res_dy_n;
            res_mask <= res_mask_n;
        end
    end

    // Player snapshot taken when an update is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                px_q[i] <= bus.player_x[i*COORD_W +: COORD_W];
                py_q[i] <= bus.player_y[i*COORD_W +: COORD_W];
            end
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.new_ball_x     = res_x;
    assign bus.new_ball_y     = res_y;
    assign bus.new_ball_dir_x = res_dx;
    assign bus.new_ball_dir_y = res_dy;
    assign bus.hit_mask       = res_mask;
endmodule

// File: tb/tb_ball_collision_engine.sv
// tb_ball_collision_engine: directed self-checking bench for ball_collision_engine
// with two players; expectations are hand-computed from the field geometry.
module tb_ball_collision_engine;
    localparam int unsigned W  = 11;
    localparam int unsigned NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   lat;
    int   snap;

    always #5 clk = ~clk;

    ball_collision_engine_if #(.COORD_W(W), .NUM_PLAYERS(NP)) bus ();

    ball_collision_engine #(.COORD_W(W), .NUM_PLAYERS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [W-1:0] obs, input int exp);
        logic [W-1:0] e;
        e = W'(exp);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(e));
        end
    endtask

    task automatic apply(input int bx, input int by, input int dx, input int dy,
                         input int p0x, input int p0y, input int p1x, input int p1y);
        @(negedge clk);
        bus.ball_x     = W'(bx);
        bus.ball_y     = W'(by);
        bus.ball_dir_x = W'(dx);
        bus.ball_dir_y = W'(dy);
        bus.player_x   = {W'(p1x), W'(p0x)};
        bus.player_y   = {W'(p1y), W'(p0y)};
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    // Bounded wait for done; latency counts cycles after the accepting edge
    task automatic wait_done(input string tag, input bit repulse, output int n);
        n = 0;
        check({tag, "_busy"}, W'(bus.busy), 1);
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            bus.start = (repulse && n == 1);
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, W'(n), 5);
    endtask

    task automatic expect_out(input string tag, input int nx, input int ny,
                              input int ndx, input int ndy, input int m);
        check({tag, "_x"},    bus.new_ball_x, nx);
        check({tag, "_y"},    bus.new_ball_y, ny);
        check({tag, "_dx"},   bus.new_ball_dir_x, ndx);
        check({tag, "_dy"},   bus.new_ball_dir_y, ndy);
        check({tag, "_mask"}, W'(bus.hit_mask), m);
        @(negedge clk);
        check({tag, "_pulse"}, W'(bus.done), 0);
        check({tag, "_idle"},  W'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.ball_x = '0; bus.ball_y = '0; bus.ball_dir_x = '0; bus.ball_dir_y = '0;
        bus.player_x = '0; bus.player_y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(bus.busy), 0);
        check("rst_done", W'(bus.done), 0);
        check("rst_x",    bus.new_ball_x, 0);
        check("rst_y",    bus.new_ball_y, 0);
        check("rst_dx",   bus.new_ball_dir_x, 0);
        check("rst_dy",   bus.new_ball_dir_y, 0);
        check("rst_mask", W'(bus.hit_mask), 0);
        rst = 1'b0;

        // No hit
        apply(100, 100, 3, 1, 400, 300, 500, 300);
        wait_done("nohit", 1'b0, lat);
        expect_out("nohit", 103, 101, 3, 1, 0);

        // Player0 hit on the x axis, ball right of the player
        apply(110, 100, -4, 0, 100, 102, 500, 400);
        wait_done("hitx", 1'b0, lat);
`ifdef BALL_SPEEDUP_EN
        expect_out("hitx", 115, 100, 5, 0, 1);
`else
        expect_out("hitx", 114, 100, 4, 0, 1);
`endif

        // Player1 hit on the x axis, ball left of the player
        apply(95, 100, 2, 0, 500, 400, 100, 100);
        wait_done("hitxn", 1'b0, lat);
`ifdef BALL_SPEEDUP_EN
        expect_out("hitxn", 92, 100, -3, 0, 2);
`else
        expect_out("hitxn", 93, 100, -2, 0, 2);
`endif

        // Player0 hit on the y axis
        apply(100, 110, 1, -3, 102, 100, 500, 400);
        wait_done("hity", 1'b0, lat);
`ifdef BALL_SPEEDUP_EN
        expect_out("hity", 101, 114, 1, 4, 1);
`else
        expect_out("hity", 101, 113, 1, 3, 1);
`endif

        // Both players overlap; only player0 reflects
        apply(110, 100, -4, 2, 100, 102, 112, 95);
        wait_done("dbl", 1'b0, lat);
`ifdef BALL_SPEEDUP_EN
        expect_out("dbl", 115, 102, 5, 2, 3);
`else
        expect_out("dbl", 114, 102, 4, 2, 3);
`endif

        // Left and bottom walls, y clamped to 463
        apply(20, 470, -6, 5, 400, 300, 500, 300);
        wait_done("wall", 1'b0, lat);
        expect_out("wall", 26, 463, 6, -5, 0);

        // Stationary ball
        apply(20, 240, 0, 0, 400, 300, 500, 300);
        wait_done("zero", 1'b0, lat);
        expect_out("zero", 20, 240, 0, 0, 0);

        // start pulsed again while busy is ignored
        snap = done_cnt;
        apply(100, 100, 3, 1, 400, 300, 500, 300);
        wait_done("rep", 1'b1, lat);
        expect_out("rep", 103, 101, 3, 1, 0);
        repeat (10) @(negedge clk);
        check("rep_ndone", W'(done_cnt - snap), 1);

        // Reset during SCAN aborts the update
        snap = done_cnt;
        apply(110, 100, -4, 0, 100, 102, 500, 400);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ab_busy", W'(bus.busy), 0);
        check("ab_done", W'(bus.done), 0);
        check("ab_x",    bus.new_ball_x, 0);
        check("ab_dx",   bus.new_ball_dir_x, 0);
        check("ab_mask", W'(bus.hit_mask), 0);
        repeat (10) @(negedge clk);
        check("ab_ndone", W'(done_cnt - snap), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ball_collision_engine.md
# ball_collision_engine

Multi-player, sequential successor to the combinational player/ball collider. On each `start`, it latches one ball state and the positions of `NUM_PLAYERS` players. It then scans the players one per cycle, reflects the ball velocity off the first overlapping player and off the field walls, and produces the next ball position and direction with a `done` pulse. It sits in `game_controller`, between the frame-tick scheduler and the ball state registers.

## Interface
- `COORD_W`, 11: coordinate and velocity width.
- `NUM_PLAYERS`, 2: number of players scanned (≥1).
- `RADIUS`, 16: half-size of the collision box; also the wall margin.
- `FIELD_W`, 640: field width in pixels.
- `FIELD_H`, 480: field height in pixels.
- `MAX_SPEED`, 15: velocity magnitude cap, used only by the speed-up feature.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin one update; sampled only in IDLE.
- `ball_x`, `ball_y`, in, COORD_W: current ball position, unsigned.
- `ball_dir_x`, `ball_dir_y`, in, COORD_W: current velocity, signed two's complement.
- `player_x`, `player_y`, in, NUM_PLAYERS*COORD_W: packed unsigned player positions; player i occupies bits [i*COORD_W +: COORD_W].
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done`, out, 1: one-cycle pulse; all results are valid in this cycle.
- `new_ball_x`, `new_ball_y`, out, COORD_W: next position.
- `new_ball_dir_x`, `new_ball_dir_y`, out, COORD_W signed: next velocity.
- `hit_mask`, out, NUM_PLAYERS: bit i is set if player i overlapped the ball.

## Operation
- **States:** IDLE → SCAN → WALL → MOVE → DONE → IDLE.
- **IDLE:**
  - When `start` is high, latch all inputs, clear the scan index, the hit flag and the internal mask, then go to SCAN.
  - When `start` is low, stay in IDLE.
- **SCAN:** processes player `idx` each cycle.
  - Compute `ax = |bx − px|` and `ay = |by − py|` at COORD_W+2 bits.
  - Overlap means `ax < RADIUS` and `ay < RADIUS`. On overlap, set mask bit `idx`.
  - On the first overlap only (hit flag clear), reflect the velocity:
    - If `ax ≥ ay`: `dx = +|dx|` when `bx ≥ px`, otherwise `−|dx|`.
    - Otherwise: `dy = +|dy|` when `by ≥ py`, otherwise `−|dy|`.
  - Set the hit flag after the first overlap. Later overlaps update only the mask.
  - When `idx == NUM_PLAYERS−1`, go to WALL.
- **WALL:** checks both axes independently.
  - If `x + dx < RADIUS`, then `dx = +|dx|`.
  - If `x + dx > FIELD_W−1−RADIUS`, then `dx = −|dx|`.
  - The y axis uses the same rules with `FIELD_H`.
- **MOVE:** `x = clamp(x + dx, RADIUS, FIELD_W−1−RADIUS)`, and likewise for y. The sum is computed signed at COORD_W+2 bits.
- **DONE:** register all outputs, pulse `done`, return to IDLE.
- Outputs hold their values until the next DONE.
- A velocity component of 0 stays 0 through reflection.
- `start` while `busy` is ignored and not queued.
- `rst` at any time forces IDLE and clears the hit flag, mask and index. No `done` is issued for the aborted update.

## Timing
- **Reset values:** `busy=0`, `done=0`, every `new_*=0`, `hit_mask=0`.
- Edge E samples `start`. SCAN covers edges E+1 … E+NUM_PLAYERS, then WALL at E+NUM_PLAYERS+1 and MOVE at E+NUM_PLAYERS+2.
- **Latency:** `done` is high in the cycle after edge E+NUM_PLAYERS+3, i.e. NUM_PLAYERS+3 cycles after start. This is 5 cycles at the defaults.
- **Throughput:** a new `start` is accepted in the cycle after `done` at the earliest.
- `start` held high continuously yields back-to-back updates every NUM_PLAYERS+4 cycles.

## Configuration
- **`BALL_SPEEDUP_EN` defined:** after a player reflection, the magnitude of the reflected component grows by 1, saturating at `MAX_SPEED`. A reflected 0 component becomes ±1, with the same sign rule as reflection. Wall reflections never change magnitude.
- **Not defined:** magnitudes are always preserved, and `MAX_SPEED` is unused.

## Test plan
- **No hit:** ball (100,100), dir (+3,+1), players (400,300) and (500,300). Expect new (103,101), dir (3,1), mask 00, `done` 5 cycles after `start`.
- **Player hit, x axis:** ball (110,100), dir (−4,0), player0 (100,102), player1 far away. Expect dir (+4,0), new (114,100), mask 01. With `BALL_SPEEDUP_EN`: dir (+5,0), new (115,100).
- **Double overlap:** ball (110,100), dir (−4,+2), players (100,102) and (112,95). Expect mask 11. The velocity is reflected by player0 only, giving dir (+4,+2) and new (114,102).
- **Wall:** ball (20,470), dir (−6,+5), no players near. Expect dir (+6,−5) and new (26,463). Also: ball (20,240), dir (0,0) gives new (20,240) and dir (0,0).
- **Handshake and reset:**
  - `start` pulsed again while `busy` is ignored: exactly one `done` is produced.
  - `rst` asserted during SCAN: the next cycle shows IDLE, all outputs 0, and no `done`.
